// File: rtl/cen_pkg.sv
// cen_pkg: shared types for the centering sequencer.
// State encoding and read-latency limits.
package cen_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SUM       = 3'd1,
    S_SUM_FLUSH = 3'd2,
    S_DIV       = 3'd3,
    S_SUB       = 3'd4,
    S_SUB_FLUSH = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam int RD_LAT_MAX = 4;
  localparam int FL_W = $clog2(RD_LAT_MAX) + 1;

endpackage

// File: rtl/cen_sequencer_if.sv
// cen_sequencer_if: control bundle between sequencer and datapath.
// out_ready exists only when CEN_STALL_EN is defined.
interface cen_sequencer_if #(
  parameter int ADDR_W = 10
);

  logic              go;
  logic              busy;
  logic              done;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              acc_clr;
  logic              en_sum;
  logic              div_start;
  logic              div_done;
  logic              en_sub;
  logic              out_valid;
  logic              out_last;
`ifdef CEN_STALL_EN
  logic              out_ready;
`endif

  modport master (
`ifdef CEN_STALL_EN
    input  out_ready,
`endif
    input  go,
    input  div_done,
    output busy,
    output done,
    output mem_rd,
    output mem_addr,
    output acc_clr,
    output en_sum,
    output div_start,
    output en_sub,
    output out_valid,
    output out_last
  );

  modport slave (
`ifdef CEN_STALL_EN
    output out_ready,
`endif
    output go,
    output div_done,
    input  busy,
    input  done,
    input  mem_rd,
    input  mem_addr,
    input  acc_clr,
    input  en_sum,
    input  div_start,
    input  en_sub,
    input  out_valid,
    input  out_last
  );

endinterface

// File: rtl/cen_rd_pipe.sv
// cen_rd_pipe: valid delay line matching the sample RAM read latency.
// Advances only when enabled; clr_i empties it synchronously.
module cen_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic clr_i,
  input  logic adv_i,
  input  logic vld_i,
  output logic vld_o
);

  logic [RD_LAT-1:0] v_q;
  logic [RD_LAT-1:0] v_d;

  // Shift the read strobe one stage toward the output
  always_comb begin
    v_d = v_q;
    v_d[0] = vld_i;
    for (int i = 1; i < RD_LAT; i++) begin
      v_d[i] = v_q[i-1];
    end
  end

  // Hold contents while stalled, empty on clear
  always_ff @(posedge clk) begin
    if (clr_i) begin
      v_q <= '0;
    end else if (adv_i) begin
      v_q <= v_d;
    end
  end

  assign vld_o = v_q[RD_LAT-1];

endmodule

// File: rtl/cen_sequencer.sv
// cen_sequencer: single-clock enable sequencer for the centering datapath.
// Build option CEN_STALL_EN adds out_ready backpressure on the subtract pass.
module cen_sequencer
  import cen_pkg::*;
#(
  parameter int N_SAMPLES = 1024,
  parameter int ADDR_W    = 10,
  parameter int RD_LAT    = 1
) (
  input logic            clk,
  input logic            rst,
  cen_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N_SAMPLES - 1);
  localparam logic [FL_W-1:0]   LAST_F = FL_W'(RD_LAT - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [FL_W-1:0]   fl_q;
  logic              mem_rd_q;
  logic              acc_clr_q;
  logic              div_start_q;
  logic              done_q;
  logic              busy_q;

  logic pipe_v;
  logic in_sum;
  logic in_sub;
  logic stall;

  assign in_sum = (state_q == S_SUM) ||
                  (state_q == S_SUM_FLUSH);
  assign in_sub = (state_q == S_SUB) ||
                  (state_q == S_SUB_FLUSH);

`ifdef CEN_STALL_EN
  assign stall = in_sub && pipe_v && !bus.out_ready;
`else
  assign stall = 1'b0;
`endif

  cen_rd_pipe #(
    .RD_LAT(RD_LAT)
  ) u_pipe (
    .clk   (clk),
    .clr_i (rst),
    .adv_i (!stall),
    .vld_i (mem_rd_q),
    .vld_o (pipe_v)
  );

  // Frame sequencing FSM; strobes are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      fl_q        <= '0;
      mem_rd_q    <= 1'b0;
      acc_clr_q   <= 1'b0;
      div_start_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      acc_clr_q   <= 1'b0;
      div_start_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.go) begin
            state_q   <= S_SUM;
            busy_q    <= 1'b1;
            mem_rd_q  <= 1'b1;
            addr_q    <= '0;
            acc_clr_q <= 1'b1;
          end
        end
        S_SUM: begin
          if (addr_q == LAST_A) begin
            state_q  <= S_SUM_FLUSH;
            mem_rd_q <= 1'b0;
            fl_q     <= '0;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        S_SUM_FLUSH: begin
          if (fl_q == LAST_F) begin
            state_q     <= S_DIV;
            div_start_q <= 1'b1;
          end else begin
            fl_q <= fl_q + FL_W'(1);
          end
        end
        S_DIV: begin
          if (bus.div_done) begin
            state_q  <= S_SUB;
            mem_rd_q <= 1'b1;
            addr_q   <= '0;
          end
        end
        S_SUB: begin
          if (!stall) begin
            if (addr_q == LAST_A) begin
              state_q  <= S_SUB_FLUSH;
              mem_rd_q <= 1'b0;
              fl_q     <= '0;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        S_SUB_FLUSH: begin
          if (!stall) begin
            if (fl_q == LAST_F) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              fl_q <= fl_q + FL_W'(1);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          mem_rd_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = addr_q;
  assign bus.acc_clr   = acc_clr_q;
  assign bus.div_start = div_start_q;
  assign bus.en_sum    = in_sum && pipe_v;
  assign bus.en_sub    = in_sub && pipe_v;
  assign bus.out_valid = in_sub && pipe_v;
  assign bus.out_last  = (state_q == S_SUB_FLUSH) &&
                         (fl_q == LAST_F) && pipe_v;

endmodule

// File: tb/tb_cen_sequencer.sv
// tb_cen_sequencer: two sequencers (RD_LAT 1 and 3) driven by random frames.
// Expected strobe events come from a cycle-timeline model of each frame.
module tb_cen_sequencer;

  localparam int N    = 8;
  localparam int AW   = 4;
  localparam int MAXC = 2000;
  localparam int NF   = 14;

  typedef struct {
    int         cyc;
    logic [7:0] f;
    int         addr;
  } ev_t;

  logic clk = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int L = (k == 0) ? 1 : 3;

    logic rst;
    bit   fin;
    bit   go_a[MAXC];
    bit   dd_a[MAXC];
    bit   rdy_a[MAXC];
    bit   rst_a[MAXC];
    bit   busy_a[MAXC];
    logic [7:0] pf[MAXC];
    int   pa[MAXC];
    ev_t  expq[$];

    cen_sequencer_if #(.ADDR_W(AW)) bus ();

    cen_sequencer #(
      .N_SAMPLES(N),
      .ADDR_W(AW),
      .RD_LAT(L)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    // Plan every frame as a cycle timeline, then play it and enqueue
    initial begin : drv
      int p, g, d, tds, tdd, cc, j, dn, r, sp, lastc;
      bit held, rs, lvl;
      ev_t e;
      fin = 1'b0;
      for (int i = 0; i < MAXC; i++) begin
        pf[i] = '0;
        pa[i] = 0;
`ifdef CEN_STALL_EN
        rdy_a[i] = ($urandom_range(0, 3) != 0);
`else
        rdy_a[i] = 1'b1;
`endif
      end
      rst_a[0] = 1'b1;
      rst_a[1] = 1'b1;
      p = 2;
      held = 1'b0;
      for (int f = 0; f < NF; f++) begin
        g = held ? p : p + int'($urandom_range(0, 3));
        held = (f == 1) || (f > 4 && $urandom_range(0, 5) == 0);
        rs = !held && (f == 3 || (f > 4 && $urandom_range(0, 5) == 0));
        d = (f == 0) ? 4 : int'($urandom_range(1, 6));
        lvl = (f > 0) && ($urandom_range(0, 1) == 1);
        go_a[g] = 1'b1;
        pf[g + 1][6] = 1'b1;
        for (int i = 0; i < N; i++) begin
          pf[g + 1 + i][7] = 1'b1;
          pa[g + 1 + i] = i;
          pf[g + 1 + L + i][5] = 1'b1;
        end
        tds = g + N + L + 1;
        pf[tds][4] = 1'b1;
        tdd = tds + d;
        cc = tdd + 1;
        j = 0;
        while (j < N + L && cc < MAXC - 8) begin
          if (j < N) begin
            pf[cc][7] = 1'b1;
            pa[cc] = j;
          end
          if (j >= L) begin
            pf[cc][3] = 1'b1;
            pf[cc][2] = 1'b1;
            if (j - L == N - 1) pf[cc][1] = 1'b1;
          end
          if (j < L || rdy_a[cc]) j++;
          cc++;
        end
        dn = cc;
        pf[dn][0] = 1'b1;
        for (int i = g + 1; i <= dn; i++) busy_a[i] = 1'b1;
        if (lvl) begin
          for (int i = tdd; i <= dn; i++) dd_a[i] = 1'b1;
        end else begin
          dd_a[tdd] = 1'b1;
        end
        sp = int'($urandom_range(g, tds - 1));
        dd_a[sp] = 1'b1;
        if (f > 0) begin
          sp = int'($urandom_range(g + 1, dn));
          go_a[sp] = 1'b1;
        end
        if (held) begin
          for (int i = g; i <= dn; i++) go_a[i] = 1'b1;
        end
        if (rs) begin
          r = (f == 3) ? g + 5 : int'($urandom_range(g + 1, dn));
          rst_a[r] = 1'b1;
          for (int i = r + 1; i <= dn; i++) begin
            pf[i] = '0;
            busy_a[i] = 1'b0;
            dd_a[i] = 1'b0;
            go_a[i] = 1'b0;
          end
          p = r + 1;
        end else begin
          p = dn + 1;
        end
        if (p > MAXC - 120) break;
      end
      lastc = p + 4;
      for (int c = 0; c <= lastc; c++) begin
        if (c > 0) begin
          @(posedge clk);
          #1;
        end
        rst = rst_a[c];
        bus.go = go_a[c];
        bus.div_done = dd_a[c];
`ifdef CEN_STALL_EN
        bus.out_ready = rdy_a[c];
`endif
        if (pf[c] != 8'h00) begin
          e.cyc = c;
          e.f = pf[c];
          e.addr = pa[c];
          expq.push_back(e);
        end
      end
      repeat (2) @(negedge clk);
      checks++;
      if (expq.size() != 0) begin
        errors++;
        $display("FAIL L%0d leftover: %0d events never seen, required 0",
                 L, expq.size());
      end
      fin = 1'b1;
    end

    // Pop and compare whenever the DUT shows any strobe
    initial begin : mon
      int c;
      logic [7:0] got;
      ev_t e;
      c = 0;
      forever begin
        @(negedge clk);
        c++;
        got = {bus.mem_rd, bus.acc_clr, bus.en_sum, bus.div_start,
               bus.en_sub, bus.out_valid, bus.out_last, bus.done};
        checks++;
        if ($isunknown({got, bus.busy, bus.mem_addr}) || c >= MAXC ||
            bus.busy !== busy_a[c]) begin
          errors++;
          $display("FAIL L%0d busy cyc %0d: got busy %b flags %b, required busy %b",
                   L, c, bus.busy, got, (c < MAXC) ? busy_a[c] : 1'b0);
        end
        if (got != 8'h00 || (expq.size() > 0 && expq[0].cyc == c)) begin
          checks++;
          if (expq.size() == 0 || expq[0].cyc != c) begin
            errors++;
            $display("FAIL L%0d unexpected cyc %0d: got flags %b addr %0d, required none",
                     L, c, got, bus.mem_addr);
          end else begin
            e = expq.pop_front();
            if (got !== e.f ||
                (e.f[7] && int'(bus.mem_addr) != e.addr)) begin
              errors++;
              $display("FAIL L%0d event cyc %0d: got flags %b addr %0d, required flags %b addr %0d",
                       L, c, got, bus.mem_addr, e.f, e.addr);
            end
          end
        end
      end
    end
  end

  initial begin
    for (int c = 0; c < MAXC + 20; c++) begin
      @(posedge clk);
      if (g_dut[0].fin && g_dut[1].fin) break;
    end
    if (!(g_dut[0].fin && g_dut[1].fin)) begin
      checks++;
      errors++;
      $display("FAIL timeout: got unfinished drivers, required both done");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
